// File: rtl/timer_dev.sv
// Programmable countdown timer peripheral with one-shot / auto-reload modes and a single irq line.
// Latency: COUNT=PRESET two edges after EN is written; irq rises PRESET+2 edges after EN write (PRESET>=1).
// No backpressure: register writes take effect at the clock edge, reads are combinational from addr.
//
// Ports:
//   clk    - system clock, all state changes on rising edge
//   reset  - asynchronous active-high reset, clears all state
//   addr   - word select: 0=CTRL 1=PRESET 2=COUNT 3=reserved (reads 0)
//   we     - write strobe, already qualified by the bus bridge decode
//   be     - byte enables; only a full-word write (4'b1111) is accepted
//   wdata  - write data
//   rdata  - read data, combinational from addr (0 while reset is high)
//   irq    - interrupt request = pending & CTRL.IM
module timer_dev (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_en;
  logic [1:0]  r_mode;
  logic        r_im;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_pend;

  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic        w_reload;
  logic        w_hw_en_clr;
  logic        w_pend_nxt;
  logic [31:0] w_count_nxt;

  assign w_wr        = we & (be == 4'hF);
  assign w_wr_ctrl   = w_wr & (addr == A_CTRL);
  assign w_wr_preset = w_wr & (addr == A_PRESET);
  // Only MODE=01 reloads; 10 and 11 behave as one-shot.
  assign w_reload    = (r_mode == 2'b01);

  // Next-state / datapath decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_pend_nxt  = r_pend;
    w_hw_en_clr = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_en) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = S_CNT;
      end
      S_CNT: begin
        if (!r_en) begin
          w_state_nxt = S_IDLE;
        end else if (r_count > 32'd1) begin
          w_count_nxt = r_count - 32'd1;
        end else begin
          // Covers COUNT==0 as well, so a zero preset never wraps.
          w_count_nxt = 32'd0;
          w_pend_nxt  = 1'b1;
          w_state_nxt = S_INT;
        end
      end
      S_INT: begin
        if (w_reload) begin
          w_pend_nxt  = 1'b0;
          w_state_nxt = S_LOAD;
        end else begin
          w_hw_en_clr = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Software acknowledge beats any same-edge hardware set.
    if (w_wr_ctrl || w_wr_preset) w_pend_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_count  <= 32'd0;
      r_pend   <= 1'b0;
      r_en     <= 1'b0;
      r_mode   <= 2'b00;
      r_im     <= 1'b0;
      r_preset <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_pend  <= w_pend_nxt;
      // A software CTRL write overrides the one-shot hardware EN clear.
      if (w_wr_ctrl) begin
        r_en   <= wdata[0];
        r_mode <= wdata[2:1];
        r_im   <= wdata[3];
      end else if (w_hw_en_clr) begin
        r_en <= 1'b0;
      end
      if (w_wr_preset) r_preset <= wdata;
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (!reset) begin
      case (addr)
        A_CTRL:   rdata = {28'd0, r_im, r_mode, r_en};
        A_PRESET: rdata = r_preset;
        A_COUNT:  rdata = r_count;
        default:  rdata = 32'd0;
      endcase
    end
  end

  assign irq = r_pend & r_im & ~reset;

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: directed scenarios followed by random bus traffic,
// all checked against a timeline-based reference model of the timer.
// Inputs are driven between clock edges; outputs are sampled after the rising edge.
module tb_timer_dev;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  timer_dev dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .be    (be),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the timer is either idle or running a "run", described by
  // its age (edges since the load step began) and the preset latched at load.
  logic        m_en;
  logic [1:0]  m_mode;
  logic        m_im;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic        m_pend;
  logic        m_busy;
  int          m_age;
  logic [31:0] m_ld;
  int          m_len;

  task automatic model_reset();
    m_en = 0; m_mode = 0; m_im = 0; m_preset = 0; m_count = 0; m_pend = 0;
    m_busy = 0; m_age = 0; m_ld = 0; m_len = 1;
  endtask

  task automatic model_edge();
    logic        n_en, n_im, n_pend, n_busy;
    logic [1:0]  n_mode;
    logic [31:0] n_preset, n_count, n_ld;
    int          n_age, n_len;
    n_en = m_en; n_im = m_im; n_mode = m_mode; n_pend = m_pend; n_busy = m_busy;
    n_preset = m_preset; n_count = m_count; n_ld = m_ld; n_age = m_age; n_len = m_len;
    if (!m_busy) begin
      if (m_en) begin n_busy = 1; n_age = 0; end
    end else if (m_age == 0) begin
      // load step: the run lasts max(preset,1) counting edges
      n_ld = m_preset;
      n_len = (m_preset == 0) ? 1 : int'(m_preset);
      n_count = m_preset;
      n_age = 1;
    end else if (m_age <= m_len) begin
      if (!m_en) begin
        n_busy = 0;
      end else if (m_age == m_len) begin
        n_count = 0; n_pend = 1; n_age = m_age + 1;
      end else begin
        n_count = m_ld - 32'(m_age);
        n_age = m_age + 1;
      end
    end else begin
      if (m_mode == 2'b01) begin n_pend = 0; n_age = 0; end
      else begin n_en = 0; n_busy = 0; end
    end
    if (we && be == 4'hF) begin
      if (addr == 2'd0) begin
        n_en = wdata[0]; n_mode = wdata[2:1]; n_im = wdata[3]; n_pend = 0;
      end else if (addr == 2'd1) begin
        n_preset = wdata; n_pend = 0;
      end
    end
    m_en = n_en; m_im = n_im; m_mode = n_mode; m_pend = n_pend; m_busy = n_busy;
    m_preset = n_preset; m_count = n_count; m_ld = n_ld; m_age = n_age; m_len = n_len;
  endtask

  function automatic logic [31:0] model_rd(input int a);
    if (reset) return 32'd0;
    case (a)
      0: return {28'd0, m_im, m_mode, m_en};
      1: return m_preset;
      2: return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string t);
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      chk($sformatf("%s_rd%0d", t, a), rdata, model_rd(a));
    end
    chk($sformatf("%s_irq", t), {31'd0, irq}, {31'd0, (m_pend & m_im & ~reset)});
  endtask

  task automatic cyc(input logic w, input logic [1:0] a, input logic [3:0] b, input logic [31:0] d);
    we = w; addr = a; be = b; wdata = d;
    @(posedge clk);
    model_edge();
    #1;
    we = 0;
    check_all("cyc");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 2'd0, 4'h0, 32'd0);
  endtask

  int e_irq, prev, np;

  initial begin
    reset = 1; we = 0; addr = 0; be = 0; wdata = 0;
    model_reset();

    // 1. reset held, then released
    @(posedge clk); @(posedge clk); #1;
    check_all("t1_inrst");
    #2 reset = 0;
    #1 check_all("t1_post");

    // 2. one-shot with IM: irq 7 edges after the CTRL write, stays high, acked by CTRL write
    cyc(1, 2'd1, 4'hF, 32'd5);
    cyc(1, 2'd0, 4'hF, 32'h9);
    e_irq = -1;
    for (int i = 1; i <= 12; i++) begin
      idle(1);
      if (irq === 1'b1 && e_irq < 0) e_irq = i;
    end
    chk("t2_irq_edge", 32'(e_irq), 32'd7);
    chk("t2_irq_held", {31'd0, irq}, 32'd1);
    addr = 2'd0; #1;
    chk("t2_ctrl", rdata, 32'h8);
    cyc(1, 2'd0, 4'hF, 32'h8);
    chk("t2_ack", {31'd0, irq}, 32'd0);

    // 3. auto-reload: one-cycle pulse every 5 edges
    cyc(1, 2'd1, 4'hF, 32'd3);
    cyc(1, 2'd0, 4'hF, 32'hB);
    prev = -1; np = 0;
    for (int i = 1; i <= 22; i++) begin
      idle(1);
      if (irq === 1'b1) begin
        np++;
        if (prev < 0) chk("t3_first", 32'(i), 32'd5);
        else chk("t3_period", 32'(i - prev), 32'd5);
        prev = i;
      end
    end
    chk("t3_npulse", 32'(np), 32'd4);
    cyc(1, 2'd0, 4'hF, 32'h0);
    idle(3);

    // 4. PRESET rewritten mid-count, EN cleared at COUNT=4, re-enable reloads
    cyc(1, 2'd1, 4'hF, 32'd8);
    cyc(1, 2'd0, 4'hF, 32'h9);
    idle(3);
    cyc(1, 2'd1, 4'hF, 32'd10);
    for (int i = 0; i < 20; i++) begin
      addr = 2'd2; #1;
      if (rdata == 32'd4) break;
      idle(1);
    end
    cyc(1, 2'd0, 4'hF, 32'h0);
    idle(3);
    addr = 2'd2; #1;
    chk("t4_freeze", rdata, 32'd3);
    chk("t4_noirq", {31'd0, irq}, 32'd0);
    cyc(1, 2'd0, 4'hF, 32'h9);
    idle(2);
    addr = 2'd2; #1;
    chk("t4_reload", rdata, 32'd10);
    cyc(1, 2'd0, 4'hF, 32'h8);
    idle(3);

    // 5. partial-byte write, COUNT/reserved writes ignored, PRESET=0 fires after edge 3
    cyc(1, 2'd1, 4'b0011, 32'd77);
    cyc(1, 2'd2, 4'hF, 32'd123);
    cyc(1, 2'd3, 4'hF, 32'd55);
    cyc(1, 2'd1, 4'hF, 32'd0);
    cyc(1, 2'd0, 4'hF, 32'h9);
    e_irq = -1;
    for (int i = 1; i <= 8; i++) begin
      idle(1);
      if (irq === 1'b1 && e_irq < 0) e_irq = i;
    end
    chk("t5_zero_irq_edge", 32'(e_irq), 32'd3);
    cyc(1, 2'd0, 4'hF, 32'h8);
    idle(2);

    // same-edge: software CTRL write beats hardware EN clear in INT
    cyc(1, 2'd1, 4'hF, 32'd2);
    cyc(1, 2'd0, 4'hF, 32'h9);
    idle(4);
    cyc(1, 2'd0, 4'hF, 32'h9);
    addr = 2'd0; #1;
    chk("sim_ctrl", rdata, 32'h9);
    cyc(1, 2'd0, 4'hF, 32'h8);
    idle(3);
    // same-edge: PRESET write clear beats the pending set
    cyc(1, 2'd1, 4'hF, 32'd1);
    cyc(1, 2'd0, 4'hF, 32'h9);
    idle(2);
    cyc(1, 2'd1, 4'hF, 32'd1);
    chk("sim_pend", {31'd0, irq}, 32'd0);
    idle(2);

    // 6. reset while counting from 100
    cyc(1, 2'd1, 4'hF, 32'd100);
    cyc(1, 2'd0, 4'hF, 32'h9);
    idle(2);
    addr = 2'd2; #1;
    chk("t6_count", rdata, 32'd100);
    #2 reset = 1;
    model_reset();
    #1 check_all("t6_inrst");
    @(posedge clk); @(posedge clk);
    #3 reset = 0;
    #1 check_all("t6_post");
    idle(4);

    // random bus traffic
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 299));
      if (r < 200) begin
        idle(1);
      end else if (r < 235) begin
        cyc(1, 2'd0, ($urandom_range(0, 3) == 0) ? 4'h7 : 4'hF, $urandom);
      end else if (r < 270) begin
        cyc(1, 2'd1, ($urandom_range(0, 1) == 0) ? 4'(($urandom)) : 4'hF,
            32'($urandom_range(0, 6)));
      end else if (r < 298) begin
        cyc(1, 2'(2 + $urandom_range(0, 1)), 4'hF, $urandom);
      end else begin
        #2 reset = 1;
        model_reset();
        #1 check_all("rnd_inrst");
        @(posedge clk);
        #2 reset = 0;
        check_all("rnd_post");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
